// File: rtl/add_tree_mult_bcd.sv
// add_tree_mult_bcd: unsigned W x W multiplier.
// The product is formed in a registered binary add tree (one level per clock)
// and then converted to packed BCD by a shift-add-3 (double-dabble) sequencer.
// One transaction is in flight at a time. Results hold until the next one completes.
module add_tree_mult_bcd #(
   parameter int W  = 8,
   parameter int LV = 3,
   parameter int D  = 5
) (
   input  logic             clk_10kHz,
   input  logic             clrn,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [2*W-1:0]   p,
   output logic [4*D-1:0]   p_bcd,
   output logic             bcd_ovf,
   output logic             out_valid
);
   localparam int PW = 2 * W;
   localparam int CW = $clog2(PW + 1);

   // Elaboration-time parameter sanity: the tree shape depends on LV == log2(W)
   if (LV != $clog2(W) || W < 4 || W > 16 || (W & (W - 1)) != 0) begin : g_param_chk
      $error("add_tree_mult_bcd: W must be a power of two in 4..16 and LV == log2(W)");
   end

   typedef enum logic [1:0] {S_IDLE, S_TREE, S_CONV, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [W-1:0]      r_a, r_b;
   logic [CW-1:0]     r_cnt;
   logic [PW-1:0]     r_prod, r_bin;
   logic [4*D-1:0]    r_bcd, w_adj;
   logic              r_ovf;
   logic [PW-1:0]     r_p;
   logic [4*D-1:0]    r_p_bcd;
   logic              r_bcd_ovf, r_out_valid;
   logic              w_in_ready, w_acc;
   logic [PW-1:0]     w_prod;

   assign w_acc = in_valid & w_in_ready;

   // State register
   always_ff @(posedge clk_10kHz or negedge clrn) begin
      if (!clrn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next state: TREE runs LV+2 edges (partials, LV levels, load), CONV runs 2W steps
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_acc) w_next = S_TREE;
         S_TREE: if (r_cnt == '0) w_next = S_CONV;
         S_CONV: if (r_cnt == CW'(1)) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake output: operands are taken only when idle
   always_comb begin
      w_in_ready = (r_state == S_IDLE);
   end

   // Latch operands at accept; later changes on a/b are ignored
   always_ff @(posedge clk_10kHz or negedge clrn) begin
      if (!clrn) begin
         r_a <= '0;
         r_b <= '0;
      end else if (w_acc) begin
         r_a <= a;
         r_b <= b;
      end
   end

   // Add tree: level 0 holds W shifted partial products, level l holds W>>l sums
   for (genvar l = 0; l <= LV; l++) begin : g_lvl
      localparam int N = W >> l;
      logic [N-1:0][PW-1:0] r_s;
      if (l == 0) begin : g_pp
         // Partial products pp_i = (b[i] ? a : 0) << i
         always_ff @(posedge clk_10kHz or negedge clrn) begin
            if (!clrn) r_s <= '0;
            else if (r_state == S_TREE)
               for (int i = 0; i < N; i++)
                  r_s[i] <= r_b[i] ? (PW'(r_a) << i) : '0;
         end
      end else begin : g_add
         // Pairwise sums of the previous level; 2W bits never overflow
         always_ff @(posedge clk_10kHz or negedge clrn) begin
            if (!clrn) r_s <= '0;
            else if (r_state == S_TREE)
               for (int j = 0; j < N; j++)
                  r_s[j] <= g_lvl[l-1].r_s[2*j] + g_lvl[l-1].r_s[2*j+1];
         end
      end
   end

   assign w_prod = g_lvl[LV].r_s[0];

   // Double-dabble add-3 correction on every digit >= 5
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < D; i++)
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
   end

   // Phase counter and converter: load the product on the last TREE edge, then shift 2W times
   always_ff @(posedge clk_10kHz or negedge clrn) begin
      if (!clrn) begin
         r_cnt  <= '0;
         r_prod <= '0;
         r_bin  <= '0;
         r_bcd  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_acc) r_cnt <= CW'(LV + 1);
            S_TREE: begin
               if (r_cnt == '0) begin
                  r_prod <= w_prod;
                  r_bin  <= w_prod;
                  r_bcd  <= '0;
                  r_ovf  <= 1'b0;
                  r_cnt  <= CW'(PW);
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_CONV: begin
               // Bit leaving digit D-1 means the value no longer fits in D digits
               r_bcd <= {w_adj[4*D-2:0], r_bin[PW-1]};
               r_ovf <= r_ovf | w_adj[4*D-1];
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Result registers: updated only on the DONE edge, out_valid is a one-cycle pulse
   always_ff @(posedge clk_10kHz or negedge clrn) begin
      if (!clrn) begin
         r_p         <= '0;
         r_p_bcd     <= '0;
         r_bcd_ovf   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_p       <= r_prod;
            r_p_bcd   <= r_bcd;
            r_bcd_ovf <= r_ovf;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign p         = r_p;
   assign p_bcd     = r_p_bcd;
   assign bcd_ovf   = r_bcd_ovf;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_add_tree_mult_bcd.sv
// Bench for add_tree_mult_bcd: three configurations (W8/D5, W8/D4, W16/D10)
// driven one at a time, results checked against a queue-based scoreboard.
module tb_add_tree_mult_bcd;
   logic clk = 1'b0;
   initial forever #50 clk = ~clk;

   logic [2:0]  rstn = '1;
   logic [2:0]  iv   = '0;
   logic [15:0] ta[3] = '{16'd0, 16'd0, 16'd0};
   logic [15:0] tb_[3] = '{16'd0, 16'd0, 16'd0};

   logic        rdy0, ov0, vld0;  logic [15:0] p0;  logic [19:0] bcd0;
   logic        rdy1, ov1, vld1;  logic [15:0] p1;  logic [15:0] bcd1;
   logic        rdy2, ov2, vld2;  logic [31:0] p2;  logic [39:0] bcd2;

   add_tree_mult_bcd #(.W(8), .LV(3), .D(5)) u_d5 (
      .clk_10kHz(clk), .clrn(rstn[0]), .a(ta[0][7:0]), .b(tb_[0][7:0]), .in_valid(iv[0]),
      .in_ready(rdy0), .p(p0), .p_bcd(bcd0), .bcd_ovf(ov0), .out_valid(vld0));
   add_tree_mult_bcd #(.W(8), .LV(3), .D(4)) u_d4 (
      .clk_10kHz(clk), .clrn(rstn[1]), .a(ta[1][7:0]), .b(tb_[1][7:0]), .in_valid(iv[1]),
      .in_ready(rdy1), .p(p1), .p_bcd(bcd1), .bcd_ovf(ov1), .out_valid(vld1));
   add_tree_mult_bcd #(.W(16), .LV(4), .D(10)) u_w16 (
      .clk_10kHz(clk), .clrn(rstn[2]), .a(ta[2]), .b(tb_[2]), .in_valid(iv[2]),
      .in_ready(rdy2), .p(p2), .p_bcd(bcd2), .bcd_ovf(ov2), .out_valid(vld2));

   logic [63:0] m_p[3], m_bcd[3];
   logic        m_rdy[3], m_vld[3], m_ov[3];
   assign m_p[0] = 64'(p0);   assign m_bcd[0] = 64'(bcd0);
   assign m_p[1] = 64'(p1);   assign m_bcd[1] = 64'(bcd1);
   assign m_p[2] = 64'(p2);   assign m_bcd[2] = 64'(bcd2);
   assign m_rdy[0] = rdy0;  assign m_vld[0] = vld0;  assign m_ov[0] = ov0;
   assign m_rdy[1] = rdy1;  assign m_vld[1] = vld1;  assign m_ov[1] = ov1;
   assign m_rdy[2] = rdy2;  assign m_vld[2] = vld2;  assign m_ov[2] = ov2;

   typedef struct {
      int              id;
      longint unsigned a;
      longint unsigned b;
      int              e0;
   } txn_t;
   txn_t sb[$];

   int          DD[3]  = '{5, 4, 10};
   int          LAT[3] = '{22, 22, 39};
   int          n_tot = 0, n_bad = 0, cyc = 0, n_b2b = 0;
   int          n_out[3] = '{0, 0, 0};
   int          n_acc[3] = '{0, 0, 0};
   logic [63:0] last_p[3] = '{64'd0, 64'd0, 64'd0};
   bit          prev_vld[3] = '{1'b0, 1'b0, 1'b0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] bcd_of(input longint unsigned v, input int d);
      logic [63:0] r = '0;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic ovf_of(input longint unsigned v, input int d);
      longint unsigned lim = 1;
      for (int i = 0; i < d; i++) lim = lim * 10;
      return v >= lim;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Scoreboard monitor: push on accept, pop and compare on out_valid
   initial begin : mon
      txn_t t;
      longint unsigned e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rstn[k]) begin
               if (m_vld[k]) begin
                  n_out[k]++;
                  chk($sformatf("ov_pulse%0d", k), 64'(prev_vld[k]), 64'd0);
                  if (sb.size() == 0 || sb[0].id != k) begin
                     chk($sformatf("spurious_ov%0d", k), 64'd1, 64'd0);
                  end else begin
                     t = sb.pop_front();
                     e = t.a * t.b;
                     chk($sformatf("p%0d(%0d*%0d)", k, t.a, t.b), m_p[k], e);
                     chk($sformatf("p_bcd%0d(%0d*%0d)", k, t.a, t.b), m_bcd[k], bcd_of(e, DD[k]));
                     chk($sformatf("ovf%0d(%0d*%0d)", k, t.a, t.b), 64'(m_ov[k]), 64'(ovf_of(e, DD[k])));
                     chk($sformatf("latency%0d", k), 64'(cyc - t.e0), 64'(LAT[k]));
                     last_p[k] = e;
                  end
                  if (iv[k] && m_rdy[k]) n_b2b++;
               end else begin
                  chk($sformatf("p_hold%0d", k), m_p[k], last_p[k]);
               end
               if (iv[k] && m_rdy[k]) begin
                  sb.push_back('{k, longint'(ta[k]), longint'(tb_[k]), cyc + 1});
                  n_acc[k]++;
               end
            end
            prev_vld[k] = m_vld[k];
         end
      end
   end

   task automatic run(input int k, input logic [15:0] av, input logic [15:0] bv);
      bit ok = 0;
      @(posedge clk); #1;
      ta[k] = av; tb_[k] = bv; iv[k] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_rdy[k]) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      iv[k] = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("result_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int base, acc0, b0;
      #10 rstn = '0;
      #1;
      chk("rst_rdy", 64'(rdy0), 64'd1);
      chk("rst_vld", 64'(vld0), 64'd0);
      chk("rst_p", m_p[0], 64'd0);
      chk("rst_bcd", m_bcd[0], 64'd0);
      chk("rst_ovf", 64'(ov0), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rstn = '1;
      // Idle with in_valid low for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_rdy", 64'(rdy0), 64'd1);
         chk("idle_vld", 64'(vld0), 64'd0);
         chk("idle_bcd", m_bcd[0], 64'd0);
         chk("idle_ovf", 64'(ov0), 64'd0);
      end

      // Basic products and max operands, D = 5
      run(0, 1, 1);     wait_idle();
      run(0, 3, 3);     wait_idle();
      run(0, 10, 20);   wait_idle();
      run(0, 35, 20);   wait_idle();
      run(0, 125, 3);   wait_idle();
      run(0, 150, 40);  wait_idle();
      run(0, 254, 10);  wait_idle();
      run(0, 254, 11);  wait_idle();
      run(0, 255, 255); wait_idle();
      run(0, 0, 200);   wait_idle();

      // Overflow path with D = 4
      run(1, 254, 254); wait_idle();
      run(1, 254, 11);  wait_idle();
      run(1, 99, 101);  wait_idle();
      run(1, 100, 100); wait_idle();
      run(1, 255, 39);  wait_idle();

      // in_valid held high with changing operands: accepts only when ready
      acc0 = n_acc[0]; b0 = n_b2b;
      @(posedge clk); #1; iv[0] = 1'b1;
      repeat (100) begin
         ta[0] = 16'($urandom_range(0, 255));
         tb_[0] = 16'($urandom_range(0, 255));
         @(posedge clk); #1;
      end
      iv[0] = 1'b0;
      wait_idle();
      chk("cont_accepts", 64'(n_acc[0] - acc0), 64'd5);
      chk("b2b_accepts", 64'(n_b2b - b0), 64'd4);

      // Toggle in_valid while busy: no extra accepts or results
      base = n_out[0];
      run(0, 77, 99);
      acc0 = n_acc[0];
      repeat (15) begin
         @(posedge clk); #1;
         iv[0] = 1'($urandom_range(0, 1));
         ta[0] = 16'($urandom_range(0, 255));
      end
      iv[0] = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
      chk("toggle_acc", 64'(n_acc[0] - acc0), 64'd0);
      chk("toggle_out", 64'(n_out[0] - base), 64'd1);

      // Reset mid-operation at E0+10
      run(0, 200, 200);
      repeat (9) @(posedge clk);
      #1 rstn[0] = 1'b0;
      #1;
      chk("midrst_rdy", 64'(rdy0), 64'd1);
      chk("midrst_vld", 64'(vld0), 64'd0);
      chk("midrst_p", m_p[0], 64'd0);
      chk("midrst_bcd", m_bcd[0], 64'd0);
      chk("midrst_ovf", 64'(ov0), 64'd0);
      sb.delete();
      last_p[0] = '0;
      base = n_out[0];
      repeat (2) @(posedge clk);
      @(negedge clk); rstn[0] = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_no_out", 64'(n_out[0] - base), 64'd0);

      // W = 16, D = 10
      run(2, 16'hFFFF, 16'hFFFF); wait_idle();
      run(2, 12345, 54321);       wait_idle();
      run(2, 16'($urandom), 16'($urandom)); wait_idle();
      run(2, 0, 0);               wait_idle();

      chk("total_out_d5", 64'(n_out[0] > 0), 64'd1);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #(100 * 50000);
      $display("FAIL watchdog total=%0d bad=%0d", n_tot, n_bad);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/add_tree_mult_bcd.md
Name: add_tree_mult_bcd

Overview:
Parametrised successor to the 8x8 add-tree multiplier.
- Accepts one unsigned W x W operand pair per transaction through a valid/ready handshake.
- Forms the product in a registered binary add tree, one tree level per clock.
- Converts the product to packed BCD with a sequential shift-add-3 (double-dabble) FSM.
- Drives the existing 7-segment/display path with `p` and `p_bcd`, which hold until the next result.

Parameters:
- `W`, 8: operand width. Power of two, 4..16.
- `LV`, 3: add-tree depth. Must equal log2(W); elaboration fails on mismatch.
- `D`, 5: number of BCD digits in `p_bcd`. `D` smaller than ceil(2W·log10 2) is legal; the overflow flag covers it.

Ports:
- `clk_10kHz`, input, 1: system clock. All state changes on the rising edge.
- `clrn`, input, 1: reset. Asynchronous, active-low.
- `a`, input, W: multiplicand, unsigned.
- `b`, input, W: multiplier, unsigned.
- `in_valid`, input, 1: operands valid.
- `in_ready`, output, 1: block can accept operands.
- `p`, output, 2W: binary product, registered.
- `p_bcd`, output, 4D: packed BCD of `p` mod 10^D. Digit 0 is in bits [3:0].
- `bcd_ovf`, output, 1: `p` ≥ 10^D, so `p_bcd` is truncated.
- `out_valid`, output, 1: one-cycle pulse marking new `p`, `p_bcd` and `bcd_ovf`.

Behaviour:
- Reset (`clrn` = 0, asynchronous):
  - State = IDLE.
  - `in_ready` = 1; `out_valid` = 0; `bcd_ovf` = 0.
  - `p` = 0; `p_bcd` = 0.
  - All tree and converter registers = 0.
- Reset mid-operation aborts the transaction. No `out_valid` is produced for it.
- Release of `clrn` takes effect on the next rising edge; no synchroniser is needed inside the block.
- FSM states and transitions:
  - IDLE: `in_ready` = 1. Accept edge E0 = rising edge with `in_valid` & `in_ready`. At E0, latch `a` and `b` and go to TREE.
  - TREE: edge E0+1 registers W partial products, pp_i = (b[i] ? a : 0) << i, each 2W wide. Edges E0+2 .. E0+LV+1 each register one pairwise-addition level. After edge E0+LV+1 the sum is the full product; go to CONV with counter = 2W.
  - CONV: one double-dabble step per edge, 2W edges in total. Each step adds 3 to every digit ≥ 5, then shifts the product MSB into digit 0. Any bit shifted out of digit D-1 sets a sticky ovf register. Go to DONE when counter hits 0.
  - DONE: one edge. Load `p`, `p_bcd` and `bcd_ovf`, set `out_valid` = 1, set `in_ready` = 1, return to IDLE.
- Latency:
  - `out_valid` rises at edge E0 + LV + 2W + 3. For W = 8 that is E0 + 22.
  - Throughput is one transaction per LV + 2W + 3 cycles.
- `in_ready` is 0 from E0 until the DONE edge. `in_valid` while `in_ready` = 0 is ignored; operands are not queued.
- Back-to-back: a new accept is allowed in the same cycle `out_valid` is high.
- `out_valid` is exactly one cycle wide. `p`, `p_bcd` and `bcd_ovf` hold their values until the next DONE edge.
- `a` and `b` may change freely after E0; only the latched copies are used.
- Width rules:
  - All tree sums are 2W bits, which never overflows since (2^W-1)² < 2^2W.
  - Truncated BCD equals `p` mod 10^D, each digit in 0..9.

Test Plan:
- Reset and idle, W = 8, D = 5: `clrn` low for 10 µs, then high; hold `in_valid` = 0 for 10 cycles. Required: `in_ready` = 1, `out_valid` = 0, `p` = 0, `p_bcd` = 0, `bcd_ovf` = 0 throughout.
- Basic products, W = 8, D = 5: sequence (1,1), (3,3), (10,20), (35,20), (125,3), (150,40), (254,10), (254,11). Required `p` = 1, 9, 200, 700, 375, 6000, 2540, 2794. Required `p_bcd` = 0x00001, 0x00009, 0x00200, 0x00700, 0x00375, 0x06000, 0x02540, 0x02794. Each `out_valid` is exactly 22 edges after its accept.
- Maximum operands, W = 8: (255,255). Required: `p` = 65025, `p_bcd` = 0x65025, `bcd_ovf` = 0.
- Overflow, W = 8, D = 4: (254,254) → `p` = 64516, `p_bcd` = 0x4516, `bcd_ovf` = 1. Then (254,11) → `p_bcd` = 0x2794, `bcd_ovf` = 0.
- Handshake:
  - Hold `in_valid` = 1 continuously with changing operands. Required: accepts only when `in_ready` = 1, including in the `out_valid` cycle.
  - Toggle `in_valid` while busy. Required: no extra results.
  - Scoreboard: every `out_valid` matches the operands latched at its accept.
- Reset mid-op, then W = 16, D = 10:
  - Accept (200,200), assert `clrn` low at E0+10. Required: immediate reset values and no `out_valid` afterwards.
  - Rerun with W = 16, D = 10, operands (65535,65535). Required: `p` = 4294836225, `p_bcd` = 0x4294836225, latency 4 + 32 + 3 = 39 edges.
